// File: rtl/somador_pontos_time.sv
// Scoring-input controller for one team: synchronizes the +1/+2/+3 buttons, computes the
// saturated new score and holds a commit strobe. Optional undo button via SOMADOR_DESFAZER_EN.
module somador_pontos_time #(
    parameter int MAX_PONTOS  = 99,
    parameter int HOLD_CICLOS = 4
) (
    input  logic       clock,
    input  logic       clr,
    input  logic       btn_1pt,
    input  logic       btn_2pt,
    input  logic       btn_3pt,
    input  logic       btn_desfazer,
    input  logic [6:0] pontos_atual,
    output logic [6:0] soma,
    output logic       validar_soma,
    output logic       saturado,
    output logic       ocupado,
    output logic [2:0] estado
);

    localparam logic [2:0] OCIOSO  = 3'd0;
    localparam logic [2:0] CALCULA = 3'd1;
    localparam logic [2:0] VALIDA  = 3'd2;
    localparam logic [2:0] PAUSA   = 3'd3;
    localparam logic [2:0] SOLTAR  = 3'd4;

    localparam logic [6:0] MAX_P    = 7'(MAX_PONTOS);
    localparam logic [3:0] HOLD_FIM = 4'(HOLD_CICLOS - 1);

    // Button vectors are ordered {desfazer, 3pt, 2pt, 1pt}.
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] ativos;
    logic [3:0] cnt;
    logic [1:0] inc;

    always_ff @(posedge clock) begin
        if (clr) begin
            sync1 <= 4'd0;
            sync2 <= 4'd0;
        end else begin
            sync1 <= {btn_desfazer, btn_3pt, btn_2pt, btn_1pt};
            sync2 <= sync1;
        end
    end

    logic [6:0] atual_lim;
    logic [7:0] soma_larga;
    logic [6:0] soma_nova;
    logic       sat_novo;
    logic [1:0] delta;
    logic [6:0] soma_calc;
    logic       sat_calc;

    assign atual_lim  = (pontos_atual > MAX_P) ? MAX_P : pontos_atual;
    assign soma_larga = {1'b0, atual_lim} + {6'd0, inc};
    assign sat_novo   = (soma_larga > {1'b0, MAX_P});
    assign soma_nova  = sat_novo ? MAX_P : soma_larga[6:0];
    // The applied delta is at most 3, so the low two bits of the difference are exact.
    assign delta      = soma_nova[1:0] - atual_lim[1:0];

`ifdef SOMADOR_DESFAZER_EN
    logic       op_desfazer;
    logic [1:0] ultimo_inc;
    logic [6:0] desfeito;

    assign ativos   = sync2;
    assign desfeito = (atual_lim >= {5'd0, ultimo_inc}) ? (atual_lim - {5'd0, ultimo_inc}) : 7'd0;

    always_comb begin
        soma_calc = soma_nova;
        sat_calc  = sat_novo;
        if (op_desfazer) begin
            soma_calc = desfeito;
            sat_calc  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            op_desfazer <= 1'b0;
            ultimo_inc  <= 2'd0;
        end else begin
            if (estado == OCIOSO && |ativos)
                op_desfazer <= ativos[3];
            if (estado == CALCULA)
                ultimo_inc <= op_desfazer ? 2'd0 : delta;
        end
    end
`else
    logic unused_desfazer;
    logic unused_delta;

    assign ativos          = {1'b0, sync2[2:0]};
    assign soma_calc       = soma_nova;
    assign sat_calc        = sat_novo;
    assign unused_desfazer = sync2[3];
    assign unused_delta    = ^delta;
`endif

    always_ff @(posedge clock) begin
        if (clr) begin
            estado       <= OCIOSO;
            cnt          <= 4'd0;
            inc          <= 2'd0;
            soma         <= 7'd0;
            validar_soma <= 1'b0;
            saturado     <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    cnt <= 4'd0;
                    if (|ativos) begin
                        estado <= CALCULA;
                        inc    <= ativos[2] ? 2'd3 : (ativos[1] ? 2'd2 : 2'd1);
                    end
                end
                CALCULA: begin
                    estado       <= VALIDA;
                    cnt          <= 4'd0;
                    soma         <= soma_calc;
                    saturado     <= sat_calc;
                    validar_soma <= 1'b1;
                end
                VALIDA: begin
                    if (cnt == HOLD_FIM) begin
                        estado       <= PAUSA;
                        cnt          <= 4'd0;
                        validar_soma <= 1'b0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                PAUSA: begin
                    if (cnt == HOLD_FIM) begin
                        estado <= SOLTAR;
                        cnt    <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                SOLTAR: begin
                    // A held button must be released before another commit can start.
                    if (!(|ativos))
                        estado <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

    assign ocupado = (estado != OCIOSO);

endmodule
